// File: rtl/sub_mem_ctrl.sv
// Sequences captured AW/W/AR beats onto a single-port word memory, one transaction at a time.
// Define SUB_CTRL_ERR_CHECK_EN to answer out-of-range or misaligned addresses with SLVERR.
module sub_mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              aw_new,
  input  logic              w_new,
  input  logic              ar_new,
  input  logic [ADDR_W-1:0] aw_data,
  input  logic [ADDR_W-1:0] ar_data,
  input  logic [DATA_W-1:0] w_data,
  output logic              aw_hold,
  output logic              w_hold,
  output logic              ar_hold,
  output logic              b_tx_en,
  output logic              r_tx_en,
  output logic [1:0]        b_tx_data,
  output logic [DATA_W-1:0] r_tx_data,
  output logic [1:0]        r_tx_resp,
  input  logic              b_busy,
  input  logic              r_busy,
  output logic [9:0]        mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrMem  = 3'd1;
  localparam logic [2:0] StWrResp = 3'd2;
  localparam logic [2:0] StRdMem  = 3'd3;
  localparam logic [2:0] StRdWait = 3'd4;
  localparam logic [2:0] StRdResp = 3'd5;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic [2:0]        state_q, state_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic              ar_pend_q, ar_pend_d;
  logic              rd_prio_q, rd_prio_d;
  logic [1:0]        b_tx_data_q, b_tx_data_d;
  logic [1:0]        r_tx_resp_q, r_tx_resp_d;
  logic [DATA_W-1:0] r_tx_data_q, r_tx_data_d;

  logic wr_clr, rd_clr;
  logic wr_elig, rd_elig;
  logic wr_err, rd_err;

`ifdef SUB_CTRL_ERR_CHECK_EN
  assign wr_err = ((aw_data >> 12) != '0) || (aw_data[1:0] != 2'b00);
  assign rd_err = ((ar_data >> 12) != '0) || (ar_data[1:0] != 2'b00);
`else
  // Without checking, only the word index bits [11:2] matter; the address wraps at 4 KiB.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{aw_data[ADDR_W-1:12], aw_data[1:0],
                              ar_data[ADDR_W-1:12], ar_data[1:0]};
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign wr_elig = aw_pend_q && w_pend_q;
  assign rd_elig = ar_pend_q;

  // A new beat landing in the same cycle its flag clears must survive, so set beats clear.
  assign aw_pend_d = aw_new || (aw_pend_q && !wr_clr);
  assign w_pend_d  = w_new  || (w_pend_q  && !wr_clr);
  assign ar_pend_d = ar_new || (ar_pend_q && !rd_clr);

  always_comb begin
    state_d     = state_q;
    rd_prio_d   = rd_prio_q;
    b_tx_data_d = b_tx_data_q;
    r_tx_resp_d = r_tx_resp_q;
    r_tx_data_d = r_tx_data_q;
    wr_clr      = 1'b0;
    rd_clr      = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    b_tx_en     = 1'b0;
    r_tx_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // rd_prio_q marks that the last grant went to write, so read wins the next tie.
        if (wr_elig && (!rd_elig || !rd_prio_q)) begin
          state_d   = StWrMem;
          rd_prio_d = 1'b1;
        end else if (rd_elig) begin
          state_d   = StRdMem;
          rd_prio_d = 1'b0;
        end
      end
      StWrMem: begin
        mem_we      = !wr_err;
        mem_addr    = aw_data[11:2];
        mem_wdata   = w_data;
        wr_clr      = 1'b1;
        b_tx_data_d = wr_err ? RespSlvErr : RespOkay;
        state_d     = StWrResp;
      end
      StWrResp: begin
        if (!b_busy) begin
          b_tx_en = 1'b1;
          state_d = StIdle;
        end
      end
      StRdMem: begin
        mem_re      = !rd_err;
        mem_addr    = ar_data[11:2];
        rd_clr      = 1'b1;
        r_tx_resp_d = rd_err ? RespSlvErr : RespOkay;
        state_d     = StRdWait;
      end
      StRdWait: begin
        // The error is latched in RD_MEM because ar_data may be refilled once ar_hold drops.
        r_tx_data_d = (r_tx_resp_q == RespSlvErr) ? '0 : mem_rdata;
        state_d     = StRdResp;
      end
      StRdResp: begin
        if (!r_busy) begin
          r_tx_en = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A reset cycle abandons the transaction: no memory side effect or launch escapes.
    if (ARESET) begin
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      b_tx_en = 1'b0;
      r_tx_en = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      ar_pend_q   <= 1'b0;
      rd_prio_q   <= 1'b0;
      b_tx_data_q <= RespOkay;
      r_tx_resp_q <= RespOkay;
      r_tx_data_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      ar_pend_q   <= ar_pend_d;
      rd_prio_q   <= rd_prio_d;
      b_tx_data_q <= b_tx_data_d;
      r_tx_resp_q <= r_tx_resp_d;
      r_tx_data_q <= r_tx_data_d;
    end
  end

  assign aw_hold   = aw_pend_q;
  assign w_hold    = w_pend_q;
  assign ar_hold   = ar_pend_q;
  assign b_tx_data = b_tx_data_q;
  assign r_tx_resp = r_tx_resp_q;
  assign r_tx_data = r_tx_data_q;

endmodule

// File: tb/tb_sub_mem_ctrl.sv
// Self-checking bench for sub_mem_ctrl: directed vector table, multi-cycle corner sequences
// and randomized transactions checked against a transaction-level memory model.
module tb_sub_mem_ctrl;

`ifdef SUB_CTRL_ERR_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        aw_new, w_new, ar_new;
  logic [31:0] aw_data, ar_data, w_data;
  logic        aw_hold, w_hold, ar_hold;
  logic        b_tx_en, r_tx_en;
  logic [1:0]  b_tx_data, r_tx_resp;
  logic [31:0] r_tx_data;
  logic        b_busy, r_busy;
  logic [9:0]  mem_addr;
  logic        mem_we, mem_re;
  logic [31:0] mem_wdata, mem_rdata;

  sub_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .aw_new    (aw_new),
    .w_new     (w_new),
    .ar_new    (ar_new),
    .aw_data   (aw_data),
    .ar_data   (ar_data),
    .w_data    (w_data),
    .aw_hold   (aw_hold),
    .w_hold    (w_hold),
    .ar_hold   (ar_hold),
    .b_tx_en   (b_tx_en),
    .r_tx_en   (r_tx_en),
    .b_tx_data (b_tx_data),
    .r_tx_data (r_tx_data),
    .r_tx_resp (r_tx_resp),
    .b_busy    (b_busy),
    .r_busy    (r_busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  // Behavioural 1024-word memory: write on the edge, read data valid the next cycle.
  logic [31:0] tb_mem [1024];
  always @(posedge ACLK) begin
    logic [31:0] rd;
    rd = 32'h0;
    if (mem_re) rd = tb_mem[mem_addr];
    if (mem_we) tb_mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= rd;
  end

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic [9:0]  a;
    logic [1:0]  resp;
  } ev_t;

  ev_t b_q[$], r_q[$], we_q[$], re_q[$];
  int overlap = 0;

  always @(negedge ACLK) begin
    ev_t e;
    e.cyc = cyc; e.d = 32'h0; e.a = 10'h0; e.resp = 2'b00;
    if (mem_we && mem_re) overlap++;
    if (mem_we) begin e.a = mem_addr; e.d = mem_wdata; we_q.push_back(e); end
    if (mem_re) begin e.a = mem_addr; e.d = 32'h0; re_q.push_back(e); end
    if (b_tx_en) begin e.a = 10'h0; e.d = 32'h0; e.resp = b_tx_data; b_q.push_back(e); end
    if (r_tx_en) begin e.a = 10'h0; e.d = r_tx_data; e.resp = r_tx_resp; r_q.push_back(e); end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Transaction-level reference model.
  logic [31:0] ref_mem [int];

  function automatic bit addr_err(input logic [31:0] a);
    return ErrEn && ((a >= 32'h1000) || (a[1:0] != 2'b00));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (addr_err(a)) return 32'h0;
    if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (!addr_err(a)) ref_mem[widx(a)] = d;
  endtask

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Issue one write or read at the current cycle; the TX side reports busy for 'busy' cycles.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int busy, output int lat, output logic [1:0] resp,
                         output logic [31:0] rdata, output int nstb, output logic [9:0] saddr,
                         output logic [31:0] sdata);
    int t0, nb, nr, nw, nrd;
    bit seen;
    t0 = cyc; nb = b_q.size(); nr = r_q.size(); nw = we_q.size(); nrd = re_q.size();
    seen = 1'b0; lat = -1; resp = 2'b11; rdata = 32'h0; saddr = 10'h0; sdata = 32'h0;
    if (wr) begin aw_data = addr; w_data = data; aw_new = 1'b1; w_new = 1'b1; end
    else begin ar_data = addr; ar_new = 1'b1; end
    for (int n = 0; n < 64 && !seen; n++) begin
      b_busy = wr && (n < busy);
      r_busy = !wr && (n < busy);
      step();
      aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0;
      if (wr && b_q.size() > nb) begin
        seen = 1'b1; lat = b_q[nb].cyc - t0; resp = b_q[nb].resp;
      end
      if (!wr && r_q.size() > nr) begin
        seen = 1'b1; lat = r_q[nr].cyc - t0; resp = r_q[nr].resp; rdata = r_q[nr].d;
      end
    end
    b_busy = 1'b0; r_busy = 1'b0;
    chk("response_seen", 32'(seen), 32'd1);
    nstb = (we_q.size() - nw) + (re_q.size() - nrd);
    if (wr && we_q.size() > nw) begin saddr = we_q[nw].a; sdata = we_q[nw].d; end
    if (!wr && re_q.size() > nrd) saddr = re_q[nrd].a;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          busy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    int          strobes;
    logic [9:0]  maddr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          lat, nstb, t0, nb, nr, nw;
    logic [1:0]  resp;
    logic [31:0] rdata, sdata;
    logic [9:0]  saddr;

    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;

    vecs.push_back('{1'b1, 32'h010, 32'hDEADBEEF, 0, 2'b00, 32'h0, 3, 1, 10'h004});
    vecs.push_back('{1'b0, 32'h010, 32'h0, 0, 2'b00, 32'hDEADBEEF, 4, 1, 10'h004});
`ifdef SUB_CTRL_ERR_CHECK_EN
    vecs.push_back('{1'b1, 32'h1000, 32'h55555555, 0, 2'b10, 32'h0, 3, 0, 10'h000});
    vecs.push_back('{1'b0, 32'h002, 32'h0, 0, 2'b10, 32'h0, 4, 0, 10'h000});
    vecs.push_back('{1'b0, 32'h000, 32'h0, 2, 2'b00, 32'h0, 4, 1, 10'h000});
    vecs.push_back('{1'b1, 32'hFFC, 32'hCAFEF00D, 5, 2'b00, 32'h0, 5, 1, 10'h3FF});
    vecs.push_back('{1'b0, 32'hFFC, 32'h0, 7, 2'b00, 32'hCAFEF00D, 7, 1, 10'h3FF});
`else
    vecs.push_back('{1'b1, 32'h1014, 32'h12345678, 6, 2'b00, 32'h0, 6, 1, 10'h005});
    vecs.push_back('{1'b0, 32'h014, 32'h0, 0, 2'b00, 32'h12345678, 4, 1, 10'h005});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0, 2, 2'b00, 32'h0, 4, 1, 10'h0FF});
    vecs.push_back('{1'b1, 32'hFFE, 32'hCAFEF00D, 0, 2'b00, 32'h0, 3, 1, 10'h3FF});
    vecs.push_back('{1'b0, 32'hFFC, 32'h0, 7, 2'b00, 32'hCAFEF00D, 7, 1, 10'h3FF});
`endif

    ARESET = 1'b1;
    aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0;
    aw_data = 32'h0; ar_data = 32'h0; w_data = 32'h0;
    b_busy = 1'b0; r_busy = 1'b0;
    repeat (3) step();
    ARESET = 1'b0;
    #2;
    chk("rst_holds", {29'h0, aw_hold, w_hold, ar_hold}, 32'h0);
    chk("rst_strobes", {28'h0, b_tx_en, r_tx_en, mem_we, mem_re}, 32'h0);
    chk("rst_resps", {28'h0, b_tx_data, r_tx_resp}, 32'h0);
    chk("rst_r_tx_data", r_tx_data, 32'h0);
    step();

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].busy,
              lat, resp, rdata, nstb, saddr, sdata);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_resp", i), {30'h0, resp}, {30'h0, vecs[i].resp});
      chk($sformatf("vec%0d_strobes", i), 32'(nstb), 32'(vecs[i].strobes));
      if (vecs[i].strobes > 0) chk($sformatf("vec%0d_mem_addr", i), {22'h0, saddr},
                                   {22'h0, vecs[i].maddr});
      if (vecs[i].wr) begin
        if (vecs[i].strobes > 0) chk($sformatf("vec%0d_mem_wdata", i), sdata, vecs[i].data);
        model_write(vecs[i].addr, vecs[i].data);
      end else begin
        chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
      end
    end

    // Read response held off by r_busy for 5 cycles once RD_RESP is reached.
    run_txn(1'b1, 32'h080, 32'h0BADCAFE, 0, lat, resp, rdata, nstb, saddr, sdata);
    model_write(32'h080, 32'h0BADCAFE);
    t0 = cyc; nr = r_q.size();
    ar_data = 32'h080; ar_new = 1'b1;
    for (int n = 0; n < 12; n++) begin
      r_busy = (n >= 4) && (n < 9);
      #2;
      if (n >= 3 && n <= 8) chk($sformatf("busy_ar_hold_c%0d", n), 32'(ar_hold), 32'd0);
      if (n >= 4 && n <= 8) begin
        chk($sformatf("busy_r_tx_data_c%0d", n), r_tx_data, 32'h0BADCAFE);
        chk($sformatf("busy_r_tx_en_c%0d", n), 32'(r_tx_en), 32'd0);
      end
      step();
      ar_new = 1'b0;
    end
    r_busy = 1'b0;
    chk("busy_r_launches", 32'(r_q.size() - nr), 32'd1);
    if (r_q.size() > nr) begin
      chk("busy_r_latency", 32'(r_q[nr].cyc - t0), 32'd9);
      chk("busy_r_data", r_q[nr].d, 32'h0BADCAFE);
    end

    // Reset asserted during WR_MEM abandons the write.
    run_txn(1'b1, 32'h100, 32'h77777777, 0, lat, resp, rdata, nstb, saddr, sdata);
    model_write(32'h100, 32'h77777777);
    run_txn(1'b0, 32'h010, 32'h0, 0, lat, resp, rdata, nstb, saddr, sdata);
    chk("pre_reset_rdata", rdata, model_read(32'h010));
    nb = b_q.size(); nw = we_q.size();
    aw_data = 32'h100; w_data = 32'h99999999; aw_new = 1'b1; w_new = 1'b1;
    step();
    aw_new = 1'b0; w_new = 1'b0;
    step();
    ARESET = 1'b1;
    #2;
    chk("wrmem_rst_mem_we", 32'(mem_we), 32'd0);
    chk("wrmem_rst_b_tx_en", 32'(b_tx_en), 32'd0);
    step();
    ARESET = 1'b0;
    #2;
    chk("wrmem_rst_holds", {29'h0, aw_hold, w_hold, ar_hold}, 32'h0);
    chk("wrmem_rst_r_tx_data", r_tx_data, 32'h0);
    chk("wrmem_rst_resps", {28'h0, b_tx_data, r_tx_resp}, 32'h0);
    repeat (6) step();
    chk("wrmem_rst_no_write", 32'(we_q.size() - nw), 32'd0);
    chk("wrmem_rst_no_b", 32'(b_q.size() - nb), 32'd0);

    // Two back-to-back ties straight after reset: write first, then read.
    t0 = cyc; nb = b_q.size(); nr = r_q.size(); nw = we_q.size();
    aw_data = 32'h040; w_data = 32'h11111111; ar_data = 32'h040;
    aw_new = 1'b1; w_new = 1'b1; ar_new = 1'b1;
    for (int n = 0; n < 14; n++) begin
      step();
      aw_new = 1'b0; w_new = 1'b0; ar_new = 1'b0;
      if (n + 1 == 2) begin aw_new = 1'b1; w_new = 1'b1; end
      if (n + 1 == 3) w_data = 32'h22222222;
    end
    chk("tie_b_launches", 32'(b_q.size() - nb), 32'd2);
    chk("tie_r_launches", 32'(r_q.size() - nr), 32'd1);
    if (b_q.size() >= nb + 2 && r_q.size() > nr && we_q.size() >= nw + 2) begin
      chk("tie_first_b_cycle", 32'(b_q[nb].cyc - t0), 32'd3);
      chk("tie_r_cycle", 32'(r_q[nr].cyc - t0), 32'd7);
      chk("tie_r_data", r_q[nr].d, 32'h11111111);
      chk("tie_second_b_cycle", 32'(b_q[nb + 1].cyc - t0), 32'd10);
      chk("tie_second_wdata", we_q[nw + 1].d, 32'h22222222);
    end
    model_write(32'h040, 32'h11111111);
    model_write(32'h040, 32'h22222222);

    run_txn(1'b0, 32'h040, 32'h0, 0, lat, resp, rdata, nstb, saddr, sdata);
    chk("post_tie_rdata", rdata, model_read(32'h040));
    run_txn(1'b0, 32'h100, 32'h0, 0, lat, resp, rdata, nstb, saddr, sdata);
    chk("post_reset_rdata", rdata, model_read(32'h100));

    for (int k = 0; k < 40; k++) begin
      bit          wr;
      logic [31:0] a, d, exp_rd;
      int          busy, exp_lat;
      wr   = 1'($urandom_range(0, 1));
      a    = (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0) | (32'($urandom_range(0, 15)) << 2)
             | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
      d    = $urandom;
      busy = int'($urandom_range(0, 6));
      exp_lat = max2(wr ? 3 : 4, busy);
      exp_rd  = model_read(a);
      run_txn(wr, a, d, busy, lat, resp, rdata, nstb, saddr, sdata);
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_resp", k), {30'h0, resp}, addr_err(a) ? 32'd2 : 32'd0);
      chk($sformatf("rnd%0d_strobes", k), 32'(nstb), addr_err(a) ? 32'd0 : 32'd1);
      if (!addr_err(a)) chk($sformatf("rnd%0d_mem_addr", k), {22'h0, saddr}, {22'h0, a[11:2]});
      if (wr) model_write(a, d);
      else chk($sformatf("rnd%0d_rdata", k), rdata, exp_rd);
    end

    chk("we_re_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
